// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 33,
    parameter int MAX_BURST  = 8,
    parameter int IDLE_TO    = 4,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_valid,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_ready,
    output logic                          grant_vld,
    output logic [IDX_W-1:0]              grant_idx
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(IDLE_TO + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d, rr_q, rr_d, pick;
    logic [BW-1:0]    beat_q, beat_d;
    logic [TW-1:0]    to_q, to_d;
    logic             beat, rel;

    assign grant_vld = (state_q == BURST);
    assign grant_idx = grant_q;

    // first valid requester at or after rr_q; descending scan lets the nearest one win
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (req_valid[idx]) pick = IDX_W'(idx);
        end
    end

    // grant FSM next state plus combinational forwarding of the granted stream
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        beat_d     = beat_q;
        to_d       = to_q;
        req_ready  = '0;
        fifo_valid = 1'b0;
        fifo_data  = '0;
        beat       = 1'b0;
        rel        = 1'b0;
        if (state_q == IDLE) begin
            if (|req_valid) begin
                state_d = BURST;
                grant_d = pick;
                beat_d  = '0;
                to_d    = '0;
            end
        end else begin
            fifo_valid         = req_valid[grant_q];
            fifo_data          = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            req_ready[grant_q] = fifo_ready;
            beat               = fifo_valid & fifo_ready;
            beat_d             = beat_q + BW'(beat);
            to_d               = fifo_valid ? '0 : to_q + 1'b1;
            rel                = (beat & (req_last[grant_q] | (beat_d == BW'(MAX_BURST))))
                               | (to_d == TW'(IDLE_TO));
            if (rel) begin
                state_d = IDLE;
                rr_d    = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
            end
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            to_q    <= to_d;
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single upstream port of the synchronous FIFO between NUM_REQ independent producers. Each producer presents a valid/ready/data stream. The arbiter grants one producer at a time for a burst, and forwards that producer's beats to the FIFO write port with the same valid/ready semantics. A burst ends on a tagged last beat, on a beat cap, or on a producer stall timeout.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 33: payload width, matching the FIFO data width.
- MAX_BURST, 8: maximum beats per grant, ≥1.
- IDLE_TO, 4: consecutive cycles with granted req_valid low before the grant is revoked, ≥1.
- IDX_W, $clog2(NUM_REQ): width of grant_idx, derived.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester last-beat-of-burst flag; qualified by valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester ready; at most one bit high.
- fifo_valid  out  1  write valid to the FIFO upstream port.
- fifo_data  out  DATA_WIDTH  write data to the FIFO.
- fifo_ready  in  1  FIFO upstream ready (not full).
- grant_vld  out  1  a burst grant is active.
- grant_idx  out  IDX_W  index of the granted requester; holds its last value while grant_vld=0.

## Operation
- Registered state: fsm (IDLE, BURST), grant_idx, rr_ptr (IDX_W), beat_cnt (width clog2(MAX_BURST+1)), to_cnt (width clog2(IDLE_TO+1)).
- Reset values: fsm=IDLE, grant_idx=0, rr_ptr=0, beat_cnt=0, to_cnt=0.
- Outputs at reset: grant_vld=0, req_ready=0, fifo_valid=0, fifo_data=0.
- IDLE:
  - All req_ready=0, fifo_valid=0, fifo_data=0.
  - If any req_valid=1, select the first requester with valid=1 searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Load grant_idx with the selected requester, clear beat_cnt and to_cnt, go to BURST.
  - req_last is ignored in IDLE.
- BURST, with g = grant_idx:
  - Forwarding is combinational: fifo_valid=req_valid[g], fifo_data=req_data[g], req_ready[g]=fifo_ready, all other ready bits 0.
  - A beat is fifo_valid & fifo_ready. On each beat, beat_cnt increments.
  - Release conditions:
    - a beat with req_last[g]=1;
    - the beat that brings beat_cnt to MAX_BURST;
    - to_cnt reaching IDLE_TO.
  - to_cnt counts consecutive cycles with req_valid[g]=0 and clears on any cycle with req_valid[g]=1. FIFO backpressure (valid=1, ready=0) is not a stall and never times out.
  - On release: rr_ptr = (g+1) mod NUM_REQ, fsm=IDLE.
  - If last and cap coincide, there is a single release.
- Beats are never dropped or duplicated. Data order per requester is preserved. A requester not granted sees ready=0 regardless of FIFO state.
- Reset mid-burst: on the next edge, return to the reset state. A beat that completed in the same cycle as rst=1 is delivered to the FIFO (the handshake is combinational), but it is not counted.

## Timing
- Arbitration latency: req_valid sampled high in IDLE at edge N → grant_vld=1 and first possible beat in cycle N+1.
- One bubble cycle (IDLE) between consecutive bursts, including a re-grant of the same requester.
- Throughput inside a burst: 1 beat/cycle while req_valid[g] and fifo_ready are both high.
- Zero cycles of data latency; the arbiter adds no register stage on data.
- Timeout release takes effect on the edge where to_cnt reaches IDLE_TO. The grant drops IDLE_TO cycles after the first stalled cycle.

## Test plan
- **Reset:** hold rst=1 for 3 cycles with all req_valid=1 → grant_vld, req_ready, fifo_valid all 0; after release, first grant_idx=0.
- **Round-robin fairness:** all 4 requesters continuously valid, req_last on every 2nd beat, fifo_ready=1 → grants cycle 0,1,2,3,0. Each grant carries exactly 2 beats, with one bubble between bursts.
- **Burst cap:** requester 2 alone, 20 beats, no req_last, MAX_BURST=8 → bursts of 8, 8, 4 beats. Payloads arrive in order at fifo_data.
- **FIFO backpressure:** fifo_ready=0 for 10 cycles mid-burst → req_ready[g]=0, grant held, no timeout, no beat lost; the burst resumes when ready=1.
- **Stall timeout:** granted requester 1 drops valid after 3 beats while requester 3 waits → grant revoked after 4 idle cycles, rr_ptr=2, next grant_idx=3.
- **Reset mid-burst:** assert rst for 1 cycle during beat 5 of a burst → next cycle IDLE, rr_ptr=0; the subsequent grant restarts with beat_cnt=0.
